chan_mux_scan: RTL
==================

CHAN_MUX_SCAN -- requirements
Module: chan_mux_scan

Interface
REQ-001 SHALL have parameter N, default 4: channel count, power of two, 2..16.
REQ-002 SHALL have parameter W, default 1: data width per channel, 1..32.
REQ-003 SHALL have parameter DWELL, default 4: cycles spent per channel in scan mode, 1..256.
REQ-004 SHALL derive SW = log2(N) internally as the select width; it is not a user parameter.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port mode  input  1  0 = direct select, 1 = round-robin scan.
REQ-009 SHALL have port sel  input  SW  channel select, used in direct mode only.
REQ-010 SHALL have port hold  input  1  freezes scan channel and dwell count when high.
REQ-011 SHALL have port d  input  N*W  flattened channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-012 SHALL have port o  output  W  registered selected data.
REQ-013 SHALL have port o_sel  output  SW  channel index that produced o.
REQ-014 SHALL have port o_valid  output  1  o and o_sel hold a sampled value.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse when scan advances from channel N-1 to channel 0.

Function
REQ-016 SHALL implement an FSM with three states: IDLE, DIRECT and SCAN.
REQ-017 SHALL leave IDLE on the first edge with rst low: to DIRECT if mode=0, to SCAN if mode=1; o_valid stays 0 during that edge.
REQ-018 SHALL, in DIRECT, register o <= d[sel], o_sel <= sel and o_valid <= 1 on every edge: one-cycle latency, sel and d sampled together.
REQ-019 SHALL, in SCAN, register o <= d[cur], o_sel <= cur and o_valid <= 1 on every edge, where cur is the internal scan channel counter.
REQ-020 SHALL, in SCAN with hold=0, increment the dwell counter each edge; when the counter equals DWELL-1 it clears to 0 and cur advances by 1.
REQ-021 SHALL wrap cur from N-1 to 0 and assert wrap for exactly the one cycle following that advance edge.
REQ-022 SHALL, in SCAN with hold=1, keep cur and the dwell counter unchanged and never assert wrap; o still tracks live d[cur] each edge.
REQ-023 SHALL give hold priority over a pending advance or wrap on the same edge.
REQ-024 SHALL transition DIRECT->SCAN when mode=1 is sampled: cur=0, dwell=0, and the first SCAN output is d[0] one edge later.
REQ-025 SHALL transition SCAN->DIRECT when mode=0 is sampled: the same edge outputs d[sel], and the scan counters reset to 0.
REQ-026 SHALL treat DWELL=1 as advancing cur on every non-held SCAN edge.
REQ-027 SHALL ignore sel in SCAN and ignore hold in DIRECT.
REQ-028 SHALL produce only registered outputs, with no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, on any edge with rst=1, set state=IDLE, o=0, o_sel=0, o_valid=0, wrap=0, cur=0 and dwell=0, regardless of state or mode.
REQ-030 SHALL let rst asserted mid-scan abort the scan with no wrap pulse; a scan after release restarts at channel 0.
REQ-031 SHALL hold all outputs at their reset values while rst stays high.

Verification (N=4, W=4, DWELL=2 unless stated)
REQ-032 SHALL cover direct mode: d={4'hD,4'hC,4'hB,4'hA}, mode=0, sel stepped 0,1,2,3 after reset release -> o = A,B,C,D one cycle after each sel, o_sel matches, o_valid=1 from the second edge after release.
REQ-033 SHALL cover scan mode: same d, mode=1 from reset -> o sequence A,A,B,B,C,C,D,D,A; wrap high for exactly one cycle, aligned with the first A after the D pair.
REQ-034 SHALL cover hold: in SCAN at o_sel=2 with dwell=1, assert hold for 3 cycles -> o_sel stays 2, no advance; after hold drops, o_sel advances to 3 after one more edge.
REQ-035 SHALL cover hold on the wrap edge: hold high on the edge where cur=3 and dwell=1 -> wrap stays 0 and o_sel stays 3.
REQ-036 SHALL cover a mode switch and reset: SCAN at o_sel=1, then mode=0 with sel=3 -> next o=D; then mode=1 -> o=A, o_sel=0; rst pulsed mid-scan -> o=0, o_valid=0, wrap=0 the next cycle.
REQ-037 SHALL cover parameter sweep N=8, W=8, DWELL=1: o_sel cycles 0..7 on consecutive edges, with a wrap pulse every 8 cycles.

Source files
------------

// File: rtl/chan_mux_scan.sv
// Registered N-channel multiplexer with a direct-select mode and a
// round-robin scan mode that dwells DWELL cycles per channel.
module chan_mux_scan #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [$clog2(N)-1:0]   sel,
    input  logic                   hold,
    input  logic [N*W-1:0]         d,
    output logic [W-1:0]           o,
    output logic [$clog2(N)-1:0]   o_sel,
    output logic                   o_valid,
    output logic                   wrap
);

    localparam int SW = $clog2(N);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SW-1:0] CH_LAST    = SW'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    o_reg, o_next;
    logic [SW-1:0]   o_sel_reg, o_sel_next;
    logic            o_valid_reg, o_valid_next;
    logic            wrap_reg, wrap_next;
    logic            wrap_pend_reg, wrap_pend_next;
    logic [SW-1:0]   cur_reg, cur_next;
    logic [DW-1:0]   dwell_reg, dwell_next;

    logic [W-1:0]    chan [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign chan[gi] = d[gi*W +: W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            o_reg         <= '0;
            o_sel_reg     <= '0;
            o_valid_reg   <= 1'b0;
            wrap_reg      <= 1'b0;
            wrap_pend_reg <= 1'b0;
            cur_reg       <= '0;
            dwell_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            o_reg         <= o_next;
            o_sel_reg     <= o_sel_next;
            o_valid_reg   <= o_valid_next;
            wrap_reg      <= wrap_next;
            wrap_pend_reg <= wrap_pend_next;
            cur_reg       <= cur_next;
            dwell_reg     <= dwell_next;
        end
    end

    // The wrap pulse is delayed one edge so it lines up with the first
    // channel-0 sample rather than the last sample of channel N-1.
    always_comb begin
        state_next     = state_reg;
        o_next         = o_reg;
        o_sel_next     = o_sel_reg;
        o_valid_next   = o_valid_reg;
        wrap_next      = wrap_pend_reg;
        wrap_pend_next = 1'b0;
        cur_next       = cur_reg;
        dwell_next     = dwell_reg;

        case (state_reg)
            IDLE: begin
                state_next   = mode ? SCAN : DIRECT;
                o_valid_next = 1'b0;
                cur_next     = '0;
                dwell_next   = '0;
            end
            DIRECT: begin
                o_next       = chan[sel];
                o_sel_next   = sel;
                o_valid_next = 1'b1;
                cur_next     = '0;
                dwell_next   = '0;
                if (mode) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                o_valid_next = 1'b1;
                if (!mode) begin
                    state_next = DIRECT;
                    o_next     = chan[sel];
                    o_sel_next = sel;
                    cur_next   = '0;
                    dwell_next = '0;
                end else begin
                    o_next     = chan[cur_reg];
                    o_sel_next = cur_reg;
                    if (!hold) begin
                        if (dwell_reg == DWELL_LAST) begin
                            dwell_next     = '0;
                            cur_next       = cur_reg + SW'(1);
                            wrap_pend_next = (cur_reg == CH_LAST);
                        end else begin
                            dwell_next = dwell_reg + DW'(1);
                        end
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                o_valid_next = 1'b0;
            end
        endcase
    end

    assign o       = o_reg;
    assign o_sel   = o_sel_reg;
    assign o_valid = o_valid_reg;
    assign wrap    = wrap_reg;

endmodule
